// File: rtl/axi_buffer_rab_ft.sv
// axi_buffer_rab_ft
//   Valid/ready elastic FIFO for one AXI channel inside the RAB. Stores full
//   DATA_WIDTH beats in order. Any depth >= 2 is supported because the
//   pointers wrap explicitly at BUFFER_DEPTH-1. With FALL_THROUGH=1 an empty
//   buffer forwards data_in to data_out combinationally.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   flush            synchronous discard of all stored beats
//   valid_in, data_in, ready_out    upstream handshake
//   valid_out, data_out, ready_in   downstream handshake
//   elements         stored beat count (0..BUFFER_DEPTH)
//   almost_full      elements >= ALMOST_FULL_THR
//   almost_empty     elements <= ALMOST_EMPTY_THR
module axi_buffer_rab_ft #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 4,
  parameter int LOG_BUFFER_DEPTH = 2,
  parameter int FALL_THROUGH     = 0,
  parameter int ALMOST_FULL_THR  = 3,
  parameter int ALMOST_EMPTY_THR = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic                      ready_out,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [LOG_BUFFER_DEPTH:0] elements,
  output logic                      almost_full,
  output logic                      almost_empty
);

  localparam int PW = LOG_BUFFER_DEPTH;
  localparam int CW = LOG_BUFFER_DEPTH + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(BUFFER_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BUFFER_DEPTH);
  localparam logic [CW-1:0] AF_THR   = CW'(ALMOST_FULL_THR);
  localparam logic [CW-1:0] AE_THR   = CW'(ALMOST_EMPTY_THR);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0]         ptr_in, ptr_out;
  logic [CW-1:0]         count;

  logic full, empty, push, pop;
  logic bypass_mode;  // fall-through configured and nothing stored
  logic bypass_xfer;  // beat goes straight through, storage untouched
  logic write;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Depends only on state, flush and rst: no path from ready_in/valid_in,
  // so a pop at full never frees a slot in the same cycle.
  assign ready_out = !full && !flush && !rst;
  assign push      = valid_in && ready_out;

  assign bypass_mode = (FALL_THROUGH != 0) && empty;

  // push already carries the !rst/!flush gating; stored beats need it
  // explicitly so flush/reset mask a pending output.
  assign valid_out = bypass_mode ? push : (!empty && !flush && !rst);
  assign data_out  = bypass_mode ? data_in : mem[ptr_out];
  assign pop       = valid_out && ready_in;

  assign bypass_xfer = bypass_mode && push && pop;
  assign write       = push && !bypass_xfer;

  assign elements     = count;
  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ptr_in  <= '0;
      ptr_out <= '0;
      count   <= '0;
    end else if (!bypass_xfer) begin
      if (push) ptr_in  <= ptr_inc(ptr_in);
      if (pop)  ptr_out <= ptr_inc(ptr_out);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is deliberately not reset; data_out is don't-care while
  // valid_out is low.
  always_ff @(posedge clk) begin
    if (write) mem[ptr_in] <= data_in;
  end

endmodule

// File: tb/tb_axi_buffer_rab_ft.sv
module tb_axi_buffer_rab_ft;

  localparam int SOAK_N = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, id, act, exp);
    end
  endtask

  // ---------------- DUT A: depth 5, registered output ----------------
  logic       a_rst, a_fl, a_vi, a_ri;
  logic [7:0] a_di, a_dq;
  logic       a_ro, a_vo, a_af, a_ae;
  logic [3:0] a_el;

  axi_buffer_rab_ft #(
    .DATA_WIDTH(8), .BUFFER_DEPTH(5), .LOG_BUFFER_DEPTH(3), .FALL_THROUGH(0),
    .ALMOST_FULL_THR(3), .ALMOST_EMPTY_THR(1)
  ) u_a (
    .clk(clk), .rst(a_rst), .flush(a_fl), .valid_in(a_vi), .data_in(a_di),
    .ready_out(a_ro), .data_out(a_dq), .valid_out(a_vo), .ready_in(a_ri),
    .elements(a_el), .almost_full(a_af), .almost_empty(a_ae)
  );

  // ---------------- DUT B: depth 4, fall-through ----------------
  logic       b_rst, b_fl, b_vi, b_ri;
  logic [7:0] b_di, b_dq;
  logic       b_ro, b_vo, b_af, b_ae;
  logic [2:0] b_el;

  axi_buffer_rab_ft #(
    .DATA_WIDTH(8), .BUFFER_DEPTH(4), .LOG_BUFFER_DEPTH(2), .FALL_THROUGH(1),
    .ALMOST_FULL_THR(3), .ALMOST_EMPTY_THR(1)
  ) u_b (
    .clk(clk), .rst(b_rst), .flush(b_fl), .valid_in(b_vi), .data_in(b_di),
    .ready_out(b_ro), .data_out(b_dq), .valid_out(b_vo), .ready_in(b_ri),
    .elements(b_el), .almost_full(b_af), .almost_empty(b_ae)
  );

  task automatic chkb(input string nm, input int ro, input int vo, input int el, input int dat);
    chk({nm, "_ro"}, 0, 32'(b_ro), ro);
    chk({nm, "_vo"}, 1, 32'(b_vo), vo);
    chk({nm, "_el"}, 2, 32'(b_el), el);
    if (dat >= 0) chk({nm, "_dq"}, 3, 32'(b_dq), dat);
  endtask

  // ---------------- soak DUTs ----------------
  logic s_rst;
  bit   soak_go = 1'b0;
  bit   soak_done [4];

  for (genvar g = 0; g < 4; g++) begin : soak
    localparam int D  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 4 : 7;
    localparam int LG = $clog2(D);
    localparam int FT = g % 2;

    logic          vi, ri, fl;
    logic [7:0]    di, dq, seq;
    logic          ro, vo, af, ae;
    logic [LG:0]   el;
    logic [7:0]    sb [$];
    bit            e_ro, e_vo, push, pop;

    axi_buffer_rab_ft #(
      .DATA_WIDTH(8), .BUFFER_DEPTH(D), .LOG_BUFFER_DEPTH(LG), .FALL_THROUGH(FT),
      .ALMOST_FULL_THR(D - 1), .ALMOST_EMPTY_THR(1)
    ) u_s (
      .clk(clk), .rst(s_rst), .flush(fl), .valid_in(vi), .data_in(di),
      .ready_out(ro), .data_out(dq), .valid_out(vo), .ready_in(ri),
      .elements(el), .almost_full(af), .almost_empty(ae)
    );

    initial begin
      vi = 1'b0; ri = 1'b0; fl = 1'b0; di = 8'h00; seq = 8'h00;
      soak_done[g] = 1'b0;
      wait (soak_go);
      for (int c = 0; c < SOAK_N; c++) begin
        @(negedge clk);
        fl = ($urandom_range(99) == 0);
        vi = 1'($urandom_range(1));
        ri = 1'($urandom_range(1));
        di = vi ? seq : 8'($urandom);
        #1;
        e_ro = !fl && (sb.size() < D);
        e_vo = fl ? 1'b0 : (sb.size() != 0) ? 1'b1 : ((FT != 0) && vi && e_ro);
        chk("soak_ro", g * 100000 + c, 32'(ro), 32'(e_ro));
        chk("soak_vo", g * 100000 + c, 32'(vo), 32'(e_vo));
        chk("soak_el", g * 100000 + c, 32'(el), sb.size());
        chk("soak_af", g * 100000 + c, 32'(af), 32'(sb.size() >= D - 1));
        chk("soak_ae", g * 100000 + c, 32'(ae), 32'(sb.size() <= 1));
        if (e_vo) chk("soak_dq", g * 100000 + c, 32'(dq), 32'((sb.size() != 0) ? sb[0] : di));
        push = vi && e_ro;
        pop  = e_vo && ri;
        if (fl) sb.delete();
        else if (!(sb.size() == 0 && push && pop)) begin
          if (pop)  void'(sb.pop_front());
          if (push) sb.push_back(di);
        end
        if (push) seq = seq + 8'd1;
      end
      soak_done[g] = 1'b1;
    end
  end

  // ---------------- directed vectors for DUT A ----------------
  typedef struct {
    bit         rst, fl, vi, ri;
    logic [7:0] di;
    int         ro, vo, el, af, ae;  // -1 = don't care
  } vec_t;

  function automatic vec_t mk(bit rst, bit fl, bit vi, bit ri, logic [7:0] di,
                              int ro, int vo, int el, int af, int ae);
    vec_t v;
    v.rst = rst; v.fl = fl; v.vi = vi; v.ri = ri; v.di = di;
    v.ro = ro; v.vo = vo; v.el = el; v.af = af; v.ae = ae;
    return v;
  endfunction

  vec_t       tv [$];
  logic [7:0] sba [$];

  initial begin
    a_rst = 1'b1; a_fl = 1'b0; a_vi = 1'b0; a_ri = 1'b0; a_di = 8'h00;
    b_rst = 1'b1; b_fl = 1'b0; b_vi = 1'b0; b_ri = 1'b0; b_di = 8'h00;
    s_rst = 1'b1;

    //            rst fl vi ri di      ro vo el af ae
    tv.push_back(mk(1, 0, 1, 0, 8'h11, 0, 0, -1, -1, -1));
    tv.push_back(mk(1, 0, 1, 0, 8'h11, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, 0, 1, 0, 8'h11, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 8'hA0, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 8'hA1, 1, 1, 1, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 8'hA2, 1, 1, 2, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 8'hA3, 1, 1, 3, 1, 0));
    tv.push_back(mk(0, 0, 1, 0, 8'hA4, 1, 1, 4, 1, 0));
    tv.push_back(mk(0, 0, 1, 0, 8'hA5, 0, 1, 5, 1, 0));
    tv.push_back(mk(0, 0, 1, 0, 8'hA5, 0, 1, 5, 1, 0));
    tv.push_back(mk(0, 0, 1, 1, 8'hA5, 0, 1, 5, 1, 0));
    tv.push_back(mk(0, 0, 1, 1, 8'hA5, 1, 1, 4, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 1, 4, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 1, 3, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 1, 2, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 1, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 8'hB0, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 8'hB1, 1, 1, 1, 0, 1));
    tv.push_back(mk(0, 0, 1, 0, 8'hB2, 1, 1, 2, 0, 0));
    tv.push_back(mk(0, 1, 1, 1, 8'hB3, 0, 0, 3, 1, 0));
    tv.push_back(mk(0, 0, 1, 0, 8'h77, 1, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 1, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      a_rst = tv[i].rst; a_fl = tv[i].fl; a_vi = tv[i].vi;
      a_ri = tv[i].ri; a_di = tv[i].di;
      #1;
      chk("a_ro", i, 32'(a_ro), tv[i].ro);
      chk("a_vo", i, 32'(a_vo), tv[i].vo);
      if (tv[i].el >= 0) chk("a_el", i, 32'(a_el), tv[i].el);
      if (tv[i].af >= 0) chk("a_af", i, 32'(a_af), tv[i].af);
      if (tv[i].ae >= 0) chk("a_ae", i, 32'(a_ae), tv[i].ae);
      if (tv[i].vo == 1) begin
        if (sba.size() != 0) chk("a_dq", i, 32'(a_dq), 32'(sba[0]));
        else chk("a_sb_empty", i, 0, 1);
      end
      if (tv[i].rst || tv[i].fl) sba.delete();
      else begin
        if (tv[i].vo == 1 && tv[i].ri) void'(sba.pop_front());
        if (tv[i].vi && tv[i].ro == 1) sba.push_back(tv[i].di);
      end
    end
    @(negedge clk);
    a_vi = 1'b0; a_ri = 1'b0;

    // ---------------- DUT B: fall-through and full corner cases ----------------
    repeat (2) @(negedge clk);
    b_rst = 1'b0;
    b_vi = 1'b1; b_di = 8'h55; b_ri = 1'b1;
    #1 chkb("ft_bypass", 1, 1, 0, 'h55);
    @(negedge clk);
    b_vi = 1'b0;
    #1 chkb("ft_after_bypass", 1, 0, 0, -1);
    b_vi = 1'b1; b_di = 8'h55; b_ri = 1'b0;
    #1 chkb("ft_nopop", 1, 1, 0, 'h55);
    @(negedge clk);
    b_vi = 1'b0;
    #1 chkb("ft_held", 1, 1, 1, 'h55);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      b_vi = 1'b1; b_di = 8'(8'h60 + k); b_ri = 1'b0;
      #1 chkb("b_fill", 1, 1, k, 'h55);
    end
    @(negedge clk);
    b_vi = 1'b1; b_di = 8'h64; b_ri = 1'b1;
    #1 chkb("full_pop", 0, 1, 4, 'h55);
    chk("full_af", 0, 32'(b_af), 1);
    @(negedge clk);
    b_ri = 1'b0;
    #1 chkb("after_full_pop", 1, 1, 3, 'h61);
    @(negedge clk);
    b_vi = 1'b0; b_ri = 1'b1;
    #1 chkb("refill", 0, 1, 4, 'h61);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      #1 chkb("b_drain", 1, 1, 5 - k, 'h60 + k);
    end
    @(negedge clk);
    #1 chkb("b_drained", 1, 0, 0, -1);
    b_fl = 1'b1; b_vi = 1'b1; b_di = 8'h99;
    #1 chkb("ft_flush", 0, 0, 0, -1);
    @(negedge clk);
    b_fl = 1'b0; b_vi = 1'b0; b_ri = 1'b0;
    #1 chkb("ft_after_flush", 1, 0, 0, -1);

    // ---------------- random soak ----------------
    @(negedge clk);
    s_rst = 1'b1;
    repeat (2) @(negedge clk);
    s_rst = 1'b0;
    soak_go = 1'b1;
    for (int c = 0; c < SOAK_N + 200; c++) begin
      if (soak_done[0] && soak_done[1] && soak_done[2] && soak_done[3]) break;
      @(negedge clk);
    end
    chk("soak_finished", 0,
        32'(soak_done[0] && soak_done[1] && soak_done[2] && soak_done[3]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
